// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (LSU_SIZE_B/H/W; encoding 3 is reserved and
//     handled as a word access by every consumer)
//   - lsu_state_e: control FSM states
//   - strobe-width derivation from the data width
package lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic int lsu_strb_width(input int data_width);
        return data_width / 8;
    endfunction

    localparam int LSU_STRB_WIDTH = lsu_strb_width(LSU_DATA_WIDTH);

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane steering for the load/store unit.
//   Store side: replicates byte/half store data across all lanes and builds
//   the byte strobe from the low address bits.
//   Load side: shifts the raw memory word down to the addressed byte and
//   sign- or zero-extends the byte/half result.
// Ports:
//   size        access size (B/H/W, 3 = word)
//   is_unsigned zero-extend byte/half loads
//   addr_lo     effective address bits [1:0]
//   st_data     store data as supplied by the core
//   st_wdata    lane-replicated store data
//   st_wstrb    byte strobes (not gated by store/load)
//   ld_raw      raw word returned by memory
//   ld_data     aligned and extended load result
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [DATA_WIDTH-1:0] st_wdata,
    output logic [STRB_WIDTH-1:0] st_wstrb,
    input  logic [DATA_WIDTH-1:0] ld_raw,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [DATA_WIDTH-1:0] ld_shift;
    logic                  ext_b;
    logic                  ext_h;

    always_comb begin
        ld_shift = ld_raw >> {addr_lo, 3'b000};
        // Sign bit of the narrow result, forced to 0 for unsigned loads.
        ext_b    = ld_shift[7]  & ~is_unsigned;
        ext_h    = ld_shift[15] & ~is_unsigned;

        st_wdata = st_data;
        st_wstrb = '1;
        ld_data  = ld_shift;

        case (size)
            LSU_SIZE_B: begin
                st_wdata = {(DATA_WIDTH/8){st_data[7:0]}};
                st_wstrb = {{(STRB_WIDTH-1){1'b0}}, 1'b1} << addr_lo;
                ld_data  = {{(DATA_WIDTH-8){ext_b}}, ld_shift[7:0]};
            end
            LSU_SIZE_H: begin
                st_wdata = {(DATA_WIDTH/16){st_data[15:0]}};
                // A half at offset 3 loses its upper strobe off the top.
                st_wstrb = {{(STRB_WIDTH-2){1'b0}}, 2'b11} << addr_lo;
                ld_data  = {{(DATA_WIDTH-16){ext_h}}, ld_shift[15:0]};
            end
            default: begin
                // Word and reserved size: data unchanged, all strobes,
                // extension flag ignored.
                st_wdata = st_data;
                st_wstrb = '1;
                ld_data  = ld_shift;
            end
        endcase
    end

endmodule

// File: rtl/lsu_core.sv
// lsu_core: blocking load/store unit between execute and writeback.
//   Accepts one access from execute, issues a single-beat request on the
//   data-memory port, and returns the extended load data (or store
//   completion) to writeback. One access outstanding at a time.
// Optional build macro:
//   LSU_MISALIGN_CHECK_EN - misaligned half/word accesses skip memory and
//                           complete one cycle after accept with out_err = 1.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_*              request from execute (valid/ready)
//   mem_req_*         request to data memory (valid/ready)
//   mem_resp_*        response from data memory (valid/ready)
//   out_*             result to writeback (valid/ready)
module lsu_core
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic                  in_we,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_we,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [STRB_WIDTH-1:0] mem_req_wstrb,

    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    input  logic                  mem_resp_err,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_err
);

    lsu_state_e state_q;
    lsu_state_e state_d;

    // Access captured at accept; drives the whole request and extraction.
    logic [DATA_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic                  we_p0;
    logic [1:0]            size_p0;
    logic                  uns_p0;

    // Result held for writeback.
    logic [DATA_WIDTH-1:0] rdata_p1;
    logic                  err_p1;

    logic                  accept;
    logic                  misalign;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [STRB_WIDTH-1:0] al_wstrb;
    logic [DATA_WIDTH-1:0] al_ldata;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (in_size)
            LSU_SIZE_B: misalign = 1'b0;
            LSU_SIZE_H: misalign = in_addr[0];
            default:    misalign = (in_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign accept = (state_q == IDLE) && in_valid;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_align (
        .size        (size_p0),
        .is_unsigned (uns_p0),
        .addr_lo     (addr_p0[1:0]),
        .st_data     (wdata_p0),
        .st_wdata    (al_wdata),
        .st_wstrb    (al_wstrb),
        .ld_raw      (mem_resp_rdata),
        .ld_data     (al_ldata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        out_valid      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = misalign ? DONE : REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_resp_ready = 1'b1;
                if (mem_resp_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: capture the access at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p0  <= '0;
            wdata_p0 <= '0;
            we_p0    <= 1'b0;
            size_p0  <= LSU_SIZE_B;
            uns_p0   <= 1'b0;
        end else if (accept) begin
            addr_p0  <= in_addr;
            wdata_p0 <= in_wdata;
            we_p0    <= in_we;
            size_p0  <= in_size;
            uns_p0   <= in_unsigned;
        end
    end

    // Stage p1: result for writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (accept && misalign) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b1;
        end else if ((state_q == WAIT) && mem_resp_valid) begin
            // Stores report zero data; only the bus error is forwarded.
            rdata_p1 <= we_p0 ? '0 : al_ldata;
            err_p1   <= mem_resp_err;
        end
    end

    assign mem_req_addr  = {addr_p0[DATA_WIDTH-1:2], 2'b00};
    assign mem_req_we    = we_p0;
    assign mem_req_wdata = al_wdata;
    assign mem_req_wstrb = we_p0 ? al_wstrb : '0;
    assign out_rdata     = rdata_p1;
    assign out_err       = err_p1;

endmodule

// File: doc/lsu_core.md
Name: lsu_core

Overview:
Load/store unit in the execute→memory path. It consumes the effective address produced by the integer ALU, together with the store data and access type. It issues one single-beat request on the data-memory port, then returns aligned and extended load data, or store completion, to writeback. It is a blocking unit with one access outstanding at a time, and uses valid/ready handshakes on all three interfaces.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  access request from execute
- in_ready  out  1  unit can accept a request
- in_addr  in  32  effective address (ALU result)
- in_wdata  in  32  store data (rs2)
- in_we  in  1  1 = store, 0 = load
- in_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word
- in_unsigned  in  1  zero-extend load (lbu/lhu)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_req_we  out  1  write enable
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte strobes; zero for loads
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  unit accepts response
- mem_resp_rdata  in  32  raw word read
- mem_resp_err  in  1  bus error
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_rdata  out  32  extended load data; 0 for stores
- out_err  out  1  access fault (bus error or misaligned)

Behaviour:
- Reset: the FSM returns to IDLE asynchronously. All outputs except in_ready are 0; in_ready is 1. All captured registers are cleared.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid, capture addr, wdata, we, size, unsigned. Go to REQ, or to DONE with err = 1 on a misaligned access (feature only).
  - REQ: mem_req_valid = 1, with all req fields driven from captured registers and held stable until mem_req_ready. On the handshake, go to WAIT.
  - WAIT: mem_resp_ready = 1. On mem_resp_valid, register the extracted data and resp_err, then go to DONE.
  - DONE: out_valid = 1, with out_rdata and out_err held stable until out_ready. Then go to IDLE.
- in_ready is high only in IDLE; there is no accept in the same cycle that DONE retires.
- Latency with a zero-wait memory: accept at cycle N, req_valid at N+1, resp accepted at N+2, out_valid at N+3.
- Store alignment:
  - wdata: byte → {4{b}}, half → {2{h}}, word → unchanged.
  - wstrb: byte → 4'b0001 << a[1:0]; half → 4'b0011 << a[1:0]; word → 4'b1111.
- Load extraction: shift rdata right by a[1:0]*8, take the low 8/16/32 bits, then sign-extend or zero-extend per in_unsigned. Word loads ignore in_unsigned.
- mem_resp_valid is ignored outside WAIT; a stale response after reset is dropped.
- Reset asserted in any state aborts the access. No request or response is retained.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: a half access with a[0] = 1, or a word access with a[1:0] != 0, issues no memory request. The FSM goes IDLE→DONE directly, with out_err = 1 and out_rdata = 0, so out_valid rises 1 cycle after accept.
- Undefined: no check is made and every access goes to memory.
  - A misaligned half at a[1:0] = 3 produces wstrb 4'b1000 (strobe shifted off the top), and loads return the shifted partial data.
  - out_err reflects mem_resp_err only.

Decomposition:
- Shared package/defines:
  - size encodings LSU_SIZE_B/H/W
  - lsu_state_e enum {IDLE, REQ, WAIT, DONE}
  - the STRB_WIDTH derivation
- One sub-module, lsu_align: purely combinational. It generates store wdata/wstrb, and performs load extract/extend from (size, unsigned, a[1:0]). It is unit-testable standalone.

Test Plan:
1. sw addr 0x80000004, wdata 0xDEADBEEF, zero-wait memory → req_addr 0x80000004, we = 1, wstrb 4'hF, wdata 0xDEADBEEF; out_valid 3 cycles after accept, out_rdata 0, err 0.
2. lb at 0x80000003, rdata 0x8A112233 → out_rdata 0xFFFFFF8A; the same access as lbu → 0x0000008A; lh at 0x80000002 → 0xFFFF8A11.
3. sh addr 0x80000002, wdata 0x00001234 → wdata 0x12341234, wstrb 4'b1100, req_addr 0x80000000.
4. lw at 0x80000001 with LSU_MISALIGN_CHECK_EN → no req_valid, out_valid at accept+1, out_err 1. Without the macro → request is issued to 0x80000000.
5. Stalls: req_ready low for 5 cycles → req fields stable throughout. Then out_ready low for 3 cycles → out_valid/out_rdata held and in_ready stays 0. mem_resp_err = 1 → out_err 1.
6. rst_n pulsed low in WAIT → outputs cleared immediately. A resp_valid arriving after release is ignored. A following lw completes correctly.
